// File: rtl/alu_arbiter_if.sv
// Request/response channel bundle between the two clients and the ALU arbiter.
// Bit i of every 2-bit handshake vector belongs to requester i.
interface alu_arbiter_if #(parameter int WIDTH = 8);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_b0;
  logic [1:0]       req_op0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b1;
  logic [1:0]       req_op1;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_y;
  logic             rsp_c;
  logic             rsp_n;
  logic             rsp_z;

  modport master (
    output req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_c, rsp_n, rsp_z
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_c, rsp_n, rsp_z
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external combinational ALU between two requesters.
// Sequence per transaction: accept (IDLE) -> ALU evaluates latched operands (EXEC) -> hand back (RESP).
module alu_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_c,
  input  logic             alu_n,
  input  logic             alu_z,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             prio;
  logic             owner;
  logic             gnt;
  logic             accept;
  logic             rsp_done;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [1:0]       rsp_valid_q;
  logic [WIDTH-1:0] rsp_y_q;
  logic             rsp_c_q;
  logic             rsp_n_q;
  logic             rsp_z_q;

  // SUB uses the ALU's subtract-enable bit, hence the gap in the encoding.
  function automatic logic [2:0] op_to_ctrl(input logic [1:0] op);
    case (op)
      2'b11:   op_to_ctrl = 3'b110;
      default: op_to_ctrl = {1'b0, op};
    endcase
  endfunction

  assign gnt      = (&bus.req_valid) ? prio : bus.req_valid[1];
  assign accept   = (state == IDLE) && (|bus.req_valid);
  assign rsp_done = (state == RESP) && bus.rsp_ready[owner];

  assign bus.req_ready = (state == IDLE && bus.req_valid[gnt]) ?
                         (gnt ? 2'b10 : 2'b01) : 2'b00;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_c     = rsp_c_q;
  assign bus.rsp_n     = rsp_n_q;
  assign bus.rsp_z     = rsp_z_q;

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_ctrl = op_to_ctrl(op_q);
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = EXEC;
      EXEC:                  state_nxt = RESP;
      RESP:    if (rsp_done) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prio        <= 1'b0;
      owner       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 2'b00;
      rsp_valid_q <= 2'b00;
      rsp_y_q     <= '0;
      rsp_c_q     <= 1'b0;
      rsp_n_q     <= 1'b0;
      rsp_z_q     <= 1'b0;
      op_count    <= '0;
    end else begin
      state <= state_nxt;
      // accept stage: latch the granted requester's fields
      if (accept) begin
        owner <= gnt;
        prio  <= ~gnt;
        a_q   <= gnt ? bus.req_a1  : bus.req_a0;
        b_q   <= gnt ? bus.req_b1  : bus.req_b0;
        op_q  <= gnt ? bus.req_op1 : bus.req_op0;
      end
      // capture stage: ALU output is settled from the latched operands
      if (state == EXEC) begin
        rsp_y_q            <= alu_y;
        rsp_c_q            <= alu_c;
        rsp_n_q            <= alu_n;
        rsp_z_q            <= alu_z;
        rsp_valid_q[owner] <= 1'b1;
      end
      // hand-back stage
      if (rsp_done) begin
        rsp_valid_q <= 2'b00;
        op_count    <= op_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized, self-checking bench for alu_arbiter with a behavioural ALU and reference model.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] alu_a, alu_b, alu_y;
  logic [2:0] alu_ctrl;
  logic       alu_c, alu_n, alu_z, busy;
  logic [3:0] op_count;
  logic [8:0] alu_t;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_count = 0;

  alu_arbiter_if #(.WIDTH(8)) bus ();

  alu_arbiter #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_y(alu_y), .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // External ALU, decoded from alu_ctrl
  always_comb begin
    alu_t = 9'h000;
    alu_c = 1'b0;
    alu_n = 1'b0;
    case (alu_ctrl)
      3'b000: alu_t = {1'b0, alu_a & alu_b};
      3'b001: alu_t = {1'b0, alu_a | alu_b};
      3'b010: begin
        alu_t = {1'b0, alu_a} + {1'b0, alu_b};
        alu_c = alu_t[8];
        alu_n = alu_t[7];
      end
      3'b110: begin
        alu_t = {1'b0, alu_a} - {1'b0, alu_b};
        alu_c = alu_t[8];
        alu_n = alu_t[8];
      end
      default: alu_t = 9'h1A5;
    endcase
    alu_y = alu_t[7:0];
    alu_z = (alu_y == 8'h00);
  end

  // Reference result computed from the request op with integer arithmetic
  function automatic void ref_alu(input int a, input int b, input int op,
                                  output logic [7:0] y, output logic c,
                                  output logic n, output logic z);
    int r;
    c = 1'b0;
    n = 1'b0;
    case (op)
      0: r = a & b;
      1: r = a | b;
      2: begin r = a + b; c = (r > 255); end
      default: begin r = a - b; c = (r < 0); n = c; end
    endcase
    r = (r + 256) % 256;
    if (op == 2) n = (r >= 128);
    y = 8'(r);
    z = (r == 0);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one transaction on requester r; waits are bounded and report via timeout.
  task automatic run_txn(input int r, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, output logic timeout,
                         output logic [1:0] rdy_seen, output int lat,
                         output logic [2:0] ctrl_exec, output logic [1:0] vld_seen,
                         output logic [7:0] y, output logic c, output logic n,
                         output logic z);
    int k;
    timeout = 1'b0; lat = 0; rdy_seen = 2'b00; ctrl_exec = 3'b000;
    vld_seen = 2'b00; y = 8'h00; c = 1'b0; n = 1'b0; z = 1'b0;
    if (r == 0) begin bus.req_a0 = a; bus.req_b0 = b; bus.req_op0 = op; end
    else        begin bus.req_a1 = a; bus.req_b1 = b; bus.req_op1 = op; end
    bus.req_valid = (r == 0) ? 2'b01 : 2'b10;
    #1;
    k = 0;
    while (bus.req_ready == 2'b00 && k < 20) begin @(posedge clk); #1; k++; end
    if (k >= 20) begin timeout = 1'b1; bus.req_valid = 2'b00; return; end
    rdy_seen = bus.req_ready;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    ctrl_exec = alu_ctrl;
    lat = 1;
    k = 0;
    while (bus.rsp_valid == 2'b00 && k < 20) begin @(posedge clk); #1; lat++; k++; end
    if (k >= 20) begin timeout = 1'b1; return; end
    vld_seen = bus.rsp_valid;
    y = bus.rsp_y; c = bus.rsp_c; n = bus.rsp_n; z = bus.rsp_z;
    k = 0;
    while (bus.rsp_valid != 2'b00 && k < 40) begin @(posedge clk); #1; k++; end
    if (k >= 40) timeout = 1'b1;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_count = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.req_valid = 2'b00; bus.rsp_ready = 2'b11;
    bus.req_a0 = 8'h00; bus.req_b0 = 8'h00; bus.req_op0 = 2'b00;
    bus.req_a1 = 8'h00; bus.req_b1 = 8'h00; bus.req_op1 = 2'b00;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_y, bus.rsp_c, bus.rsp_n, bus.rsp_z} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_rsp: got valid=%b y=%h c%b n%b z%b, expected all zero",
               bus.rsp_valid, bus.rsp_y, bus.rsp_c, bus.rsp_n, bus.rsp_z);
    end
    n_tests++;
    if ({alu_a, alu_b, alu_ctrl, busy, op_count, bus.req_ready} !== 26'h0) begin
      n_fail++;
      $display("FAIL reset_ctl: got a=%h b=%h ctrl=%b busy=%b cnt=%0d rdy=%b, expected all zero",
               alu_a, alu_b, alu_ctrl, busy, op_count, bus.req_ready);
    end
    rst_n = 1'b1;
    exp_count = 0;
  endtask

  task automatic test_add_r0();
    logic to, c, n, z, ec, en, ez;
    logic [1:0] rdy, vld;
    logic [2:0] ctl;
    logic [7:0] y, ey;
    int lat;
    bus.rsp_ready = 2'b11;
    ref_alu(8'hFF, 8'h01, 2, ey, ec, en, ez);
    run_txn(0, 8'hFF, 8'h01, 2'b10, to, rdy, lat, ctl, vld, y, c, n, z);
    exp_count++;
    n_tests++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL add_timeout: got timeout=1, expected 0"); end
    n_tests++;
    if (rdy !== 2'b01) begin n_fail++; $display("FAIL add_ready: got %b expected 01", rdy); end
    n_tests++;
    if (lat !== 2) begin n_fail++; $display("FAIL add_latency: got %0d expected 2", lat); end
    n_tests++;
    if (vld !== 2'b01) begin n_fail++; $display("FAIL add_rsp_valid: got %b expected 01", vld); end
    n_tests++;
    if ({y, c, n, z} !== {ey, ec, en, ez}) begin
      n_fail++;
      $display("FAIL add_result: got y=%h c%b n%b z%b expected y=%h c%b n%b z%b", y, c, n, z, ey, ec, en, ez);
    end
    n_tests++;
    if (op_count !== 4'(exp_count)) begin
      n_fail++; $display("FAIL add_count: got %0d expected %0d", op_count, exp_count % 16);
    end
  endtask

  task automatic test_sub_r1();
    logic to, c, n, z, ec, en, ez;
    logic [1:0] rdy, vld;
    logic [2:0] ctl;
    logic [7:0] y, ey;
    int lat;
    bus.rsp_ready = 2'b11;
    ref_alu(8'h05, 8'h07, 3, ey, ec, en, ez);
    run_txn(1, 8'h05, 8'h07, 2'b11, to, rdy, lat, ctl, vld, y, c, n, z);
    exp_count++;
    n_tests++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL sub_timeout: got timeout=1, expected 0"); end
    n_tests++;
    if (ctl !== 3'b110) begin n_fail++; $display("FAIL sub_ctrl: got %b expected 110", ctl); end
    n_tests++;
    if (vld !== 2'b10) begin n_fail++; $display("FAIL sub_rsp_valid: got %b expected 10", vld); end
    n_tests++;
    if ({y, c, n, z} !== {ey, ec, en, ez}) begin
      n_fail++;
      $display("FAIL sub_result: got y=%h c%b n%b z%b expected y=%h c%b n%b z%b", y, c, n, z, ey, ec, en, ez);
    end
  endtask

  task automatic test_alternate();
    logic [7:0] ey; logic ec, en, ez;
    logic [1:0] exp_rdy;
    int k;
    apply_reset();
    bus.rsp_ready = 2'b11;
    bus.req_a0 = 8'hF0; bus.req_b0 = 8'h0F; bus.req_op0 = 2'b00;
    bus.req_a1 = 8'hF0; bus.req_b1 = 8'h0F; bus.req_op1 = 2'b01;
    bus.req_valid = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      k = 0;
      while (bus.req_ready == 2'b00 && k < 10) begin @(posedge clk); #1; k++; end
      exp_rdy = (i % 2 == 1) ? 2'b10 : 2'b01;
      n_tests++;
      if (bus.req_ready !== exp_rdy || (i > 0 && k != 0)) begin
        n_fail++;
        $display("FAIL alt_grant%0d: got ready=%b after %0d waits, expected %b after 0", i, bus.req_ready, k, exp_rdy);
      end
      ref_alu(8'hF0, 8'h0F, (i % 2 == 1) ? 1 : 0, ey, ec, en, ez);
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_tests++;
      if ({bus.rsp_valid, bus.rsp_y, bus.rsp_z} !== {exp_rdy, ey, ez}) begin
        n_fail++;
        $display("FAIL alt_result%0d: got valid=%b y=%h z=%b expected valid=%b y=%h z=%b",
                 i, bus.rsp_valid, bus.rsp_y, bus.rsp_z, exp_rdy, ey, ez);
      end
      @(posedge clk); #1;
      exp_count++;
    end
    bus.req_valid = 2'b00;
    n_tests++;
    if (op_count !== 4'(exp_count)) begin
      n_fail++; $display("FAIL alt_count: got %0d expected %0d", op_count, exp_count % 16);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] a, b, ey; logic [1:0] op; logic ec, en, ez;
    int k;
    a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
    ref_alu(a, b, op, ey, ec, en, ez);
    bus.rsp_ready = 2'b00;
    bus.req_a0 = a; bus.req_b0 = b; bus.req_op0 = op;
    bus.req_a1 = 8'h12; bus.req_b1 = 8'h34; bus.req_op1 = 2'b10;
    bus.req_valid = 2'b01;
    #1;
    k = 0;
    while (bus.req_ready != 2'b01 && k < 10) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    bus.req_valid = 2'b10;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ({bus.rsp_valid, bus.req_ready, bus.rsp_y, bus.rsp_c, bus.rsp_n, bus.rsp_z} !==
          {2'b01, 2'b00, ey, ec, en, ez}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got valid=%b ready=%b y=%h c%b n%b z%b expected valid=01 ready=00 y=%h c%b n%b z%b",
                 i, bus.rsp_valid, bus.req_ready, bus.rsp_y, bus.rsp_c, bus.rsp_n, bus.rsp_z, ey, ec, en, ez);
      end
      bus.rsp_ready[1] = ~bus.rsp_ready[1];
      @(posedge clk); #1;
    end
    bus.rsp_ready = 2'b01;
    @(posedge clk); #1;
    exp_count++;
    n_tests++;
    if ({bus.rsp_valid, op_count, bus.req_ready} !== {2'b00, 4'(exp_count), 2'b10}) begin
      n_fail++;
      $display("FAIL bp_release: got valid=%b cnt=%0d ready=%b expected valid=00 cnt=%0d ready=10",
               bus.rsp_valid, op_count, bus.req_ready, exp_count % 16);
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
  endtask

  task automatic test_reset_mid();
    int k;
    bus.rsp_ready = 2'b11;
    bus.req_a1 = 8'h80; bus.req_b1 = 8'h80; bus.req_op1 = 2'b10;
    bus.req_valid = 2'b10;
    #1;
    k = 0;
    while (bus.req_ready == 2'b00 && k < 10) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, bus.rsp_valid, alu_a, alu_b, alu_ctrl, op_count} !== 26'h0) begin
      n_fail++;
      $display("FAIL midrst_now: got busy=%b valid=%b a=%h b=%h ctrl=%b cnt=%0d expected all zero",
               busy, bus.rsp_valid, alu_a, alu_b, alu_ctrl, op_count);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    exp_count = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({bus.rsp_valid, busy, op_count} !== 7'h0) begin
        n_fail++;
        $display("FAIL midrst_after%0d: got valid=%b busy=%b cnt=%0d expected 00/0/0",
                 i, bus.rsp_valid, busy, op_count);
      end
    end
  endtask

  task automatic test_random();
    logic to, c, n, z, ec, en, ez;
    logic [1:0] rdy, vld, op;
    logic [2:0] ctl;
    logic [7:0] y, ey, a, b;
    int lat, r;
    bus.rsp_ready = 2'b11;
    for (int i = 0; i < 24; i++) begin
      r = int'($urandom_range(1, 0));
      a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
      if (i == 0) begin a = 8'h33; b = 8'h33; op = 2'b11; end
      ref_alu(a, b, op, ey, ec, en, ez);
      run_txn(r, a, b, op, to, rdy, lat, ctl, vld, y, c, n, z);
      exp_count++;
      n_tests++;
      if ({to, vld, y, c, n, z} !== {1'b0, (r == 1) ? 2'b10 : 2'b01, ey, ec, en, ez}) begin
        n_fail++;
        $display("FAIL rand%0d: r=%0d a=%h b=%h op=%b got to=%b valid=%b y=%h c%b n%b z%b expected y=%h c%b n%b z%b",
                 i, r, a, b, op, to, vld, y, c, n, z, ey, ec, en, ez);
      end
    end
    n_tests++;
    if (op_count !== 4'(exp_count)) begin
      n_fail++; $display("FAIL rand_count: got %0d expected %0d", op_count, exp_count % 16);
    end
  endtask

  task automatic test_wrap();
    logic to, c, n, z, any_to;
    logic [1:0] rdy, vld;
    logic [2:0] ctl;
    logic [7:0] y;
    int lat;
    apply_reset();
    bus.rsp_ready = 2'b11;
    any_to = 1'b0;
    for (int i = 0; i < 15; i++) begin
      run_txn(i % 2, 8'($urandom), 8'($urandom), 2'($urandom), to, rdy, lat, ctl, vld, y, c, n, z);
      any_to = any_to | to;
      exp_count++;
    end
    n_tests++;
    if ({any_to, op_count} !== {1'b0, 4'(exp_count)}) begin
      n_fail++; $display("FAIL wrap_max: got to=%b cnt=%0d expected to=0 cnt=%0d", any_to, op_count, exp_count % 16);
    end
    run_txn(0, 8'h01, 8'h02, 2'b10, to, rdy, lat, ctl, vld, y, c, n, z);
    exp_count++;
    n_tests++;
    if ({to, op_count} !== {1'b0, 4'(exp_count)}) begin
      n_fail++; $display("FAIL wrap_zero: got to=%b cnt=%0d expected to=0 cnt=%0d", to, op_count, exp_count % 16);
    end
  endtask

  initial begin
    test_reset();
    test_add_r0();
    test_sub_r1();
    test_alternate();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
